// File: rtl/lsram_ahb_pkg.sv
// rtl/lsram_ahb_pkg.sv - shared AHB encodings and BIST FSM states
package lsram_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Beat index width: covers NUM_WORDS up to 65536.
    localparam int IDX_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_DRAIN,
        ST_RD,
        ST_RD_DRAIN,
        ST_DONE
    } bist_state_e;

endpackage

// File: rtl/lsram_bist_pattern_gen.sv
// rtl/lsram_bist_pattern_gen.sv - beat index to address and test pattern
//
// Ports:
//   idx_i     beat index within the tested region
//   addr_o    byte address of the beat (BASE_ADDR + 4*idx)
//   pattern_o data pattern for the beat (addr_o XOR SEED)
module lsram_bist_pattern_gen
    import lsram_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] SEED      = 32'hA5A5_5A5A
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [31:0]      addr_o,
    output logic [31:0]      pattern_o
);

    assign addr_o    = BASE_ADDR + {13'd0, idx_i, 2'b00};
    assign pattern_o = addr_o ^ SEED;

endmodule

// File: rtl/lsram_ahb_bist_master.sv
// rtl/lsram_ahb_bist_master.sv - AHB-Lite master running a write/read-back BIST on an LSRAM
//
// Ports:
//   HCLK, HRESETN             clock, asynchronous active-low reset
//   start                     pulse to launch a test from IDLE or DONE
//   HSEL/HADDR/HTRANS/HBURST/HSIZE/HWRITE/HWDATA  AHB master outputs
//   HREADY, HRDATA, HRESP     AHB slave responses
//   busy, done, pass          test status (done/pass sticky until next start)
//   err_cnt, err_addr         saturating mismatch count, first failing address
//   bus_err                   sticky slave error indication
module lsram_ahb_bist_master
    import lsram_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_WORDS = 1024,
    parameter logic [31:0] SEED      = 32'hA5A5_5A5A
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        start,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [16:0] err_cnt,
    output logic [31:0] err_addr,
    output logic        bus_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    bist_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;           // beat currently in (or last in) address phase
    logic             active_q, active_d;     // an address phase is being presented
    logic             dp_valid_q, dp_valid_d; // a data phase is outstanding
    logic [31:0]      dp_addr_q, dp_addr_d;
    logic [31:0]      dp_data_q, dp_data_d;   // write data, or expected read data
    logic             hwrite_q, hwrite_d;
    logic [16:0]      err_cnt_q, err_cnt_d;
    logic [31:0]      err_addr_q, err_addr_d;
    logic             bus_err_q, bus_err_d;

    logic [31:0]      pg_addr;
    logic [31:0]      pg_pattern;
    logic             first_err;

    lsram_bist_pattern_gen #(
        .BASE_ADDR (BASE_ADDR),
        .SEED      (SEED)
    ) u_pattern_gen (
        .idx_i     (idx_q),
        .addr_o    (pg_addr),
        .pattern_o (pg_pattern)
    );

    // err_addr is owned by whichever failure (mismatch or bus error) shows up first.
    assign first_err = (err_cnt_q == 17'd0) && !bus_err_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        active_d   = active_q;
        dp_valid_d = dp_valid_q;
        dp_addr_d  = dp_addr_q;
        dp_data_d  = dp_data_q;
        hwrite_d   = hwrite_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        bus_err_d  = bus_err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_WR;
                    idx_d      = '0;
                    active_d   = 1'b1;
                    dp_valid_d = 1'b0;
                    hwrite_d   = 1'b1;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    bus_err_d  = 1'b0;
                end
            end
            default: begin
                if (dp_valid_q && HRESP) begin
                    // First error cycle drops the pending address phase so HTRANS
                    // is IDLE next cycle; the test ends once the response completes.
                    bus_err_d = 1'b1;
                    active_d  = 1'b0;
                    if (first_err) err_addr_d = dp_addr_q;
                    if (HREADY) begin
                        dp_valid_d = 1'b0;
                        state_d    = ST_DONE;
                    end
                end else begin
                    if (dp_valid_q && HREADY) begin
                        dp_valid_d = 1'b0;
                        if (!hwrite_q && (HRDATA != dp_data_q)) begin
                            if (err_cnt_q != 17'h1FFFF) err_cnt_d = err_cnt_q + 17'd1;
                            if (first_err) err_addr_d = dp_addr_q;
                        end
                        if (state_q == ST_WR_DRAIN) begin
                            state_d  = ST_RD;
                            idx_d    = '0;
                            active_d = 1'b1;
                            hwrite_d = 1'b0;
                        end else if (state_q == ST_RD_DRAIN) begin
                            state_d = ST_DONE;
                        end
                    end
                    if (active_q && HREADY) begin
                        dp_valid_d = 1'b1;
                        dp_addr_d  = pg_addr;
                        dp_data_d  = pg_pattern;
                        if (idx_q == LAST_IDX) begin
                            active_d = 1'b0;
                            state_d  = hwrite_q ? ST_WR_DRAIN : ST_RD_DRAIN;
                        end else begin
                            idx_d = idx_q + 17'd1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            active_q   <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_data_q  <= '0;
            hwrite_q   <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            dp_valid_q <= dp_valid_d;
            dp_addr_q  <= dp_addr_d;
            dp_data_q  <= dp_data_d;
            hwrite_q   <= hwrite_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // A new INCR burst starts at the first beat and at every 1 KB boundary.
    always_comb begin
        HTRANS = HTRANS_IDLE;
        if (active_q) begin
            HTRANS = ((idx_q == '0) || (pg_addr[9:0] == 10'd0)) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end
    end

    assign HSEL     = active_q;
    assign HADDR    = pg_addr;
    assign HBURST   = HBURST_INCR;
    assign HSIZE    = HSIZE_WORD;
    assign HWRITE   = hwrite_q;
    assign HWDATA   = dp_data_q;
    assign busy     = (state_q == ST_WR) || (state_q == ST_WR_DRAIN) ||
                      (state_q == ST_RD) || (state_q == ST_RD_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign pass     = done && (err_cnt_q == 17'd0) && !bus_err_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_lsram_ahb_bist_master.sv
// tb/tb_lsram_ahb_bist_master.sv - directed self-checking bench for lsram_ahb_bist_master
module tb_lsram_ahb_bist_master;

    localparam logic [31:0] SEED = 32'hA5A5_5A5A;

    logic        HCLK;
    logic        HRESETN;
    int          tests;
    int          fails;

    logic        start;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;
    logic        busy;
    logic        done;
    logic        pass;
    logic [16:0] err_cnt;
    logic [31:0] err_addr;
    logic        bus_err;

    logic        b_start;
    logic        b_hsel;
    logic [31:0] b_haddr;
    logic [1:0]  b_htrans;
    logic [2:0]  b_hburst;
    logic [2:0]  b_hsize;
    logic        b_hwrite;
    logic [31:0] b_hwdata;
    logic [31:0] b_hrdata;
    logic        b_busy;
    logic        b_done;
    logic        b_pass;
    logic [16:0] b_err_cnt;
    logic [31:0] b_err_addr;
    logic        b_bus_err;

    lsram_ahb_bist_master #(
        .BASE_ADDR (32'h0000_0000),
        .NUM_WORDS (8),
        .SEED      (SEED)
    ) u_dut_a (
        .HCLK     (HCLK),
        .HRESETN  (HRESETN),
        .start    (start),
        .HSEL     (hsel),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HBURST   (hburst),
        .HSIZE    (hsize),
        .HWRITE   (hwrite),
        .HWDATA   (hwdata),
        .HREADY   (hready),
        .HRDATA   (hrdata),
        .HRESP    (hresp),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .err_addr (err_addr),
        .bus_err  (bus_err)
    );

    lsram_ahb_bist_master #(
        .BASE_ADDR (32'h0000_03F8),
        .NUM_WORDS (4),
        .SEED      (SEED)
    ) u_dut_b (
        .HCLK     (HCLK),
        .HRESETN  (HRESETN),
        .start    (b_start),
        .HSEL     (b_hsel),
        .HADDR    (b_haddr),
        .HTRANS   (b_htrans),
        .HBURST   (b_hburst),
        .HSIZE    (b_hsize),
        .HWRITE   (b_hwrite),
        .HWDATA   (b_hwdata),
        .HREADY   (1'b1),
        .HRDATA   (b_hrdata),
        .HRESP    (1'b0),
        .busy     (b_busy),
        .done     (b_done),
        .pass     (b_pass),
        .err_cnt  (b_err_cnt),
        .err_addr (b_err_addr),
        .bus_err  (b_bus_err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        wait_mode;
    logic        err_en;
    logic        flip_en;
    logic [31:0] mem [0:7];
    logic        dp_v;
    logic        dp_w;
    logic [2:0]  dp_a;
    int          wait_left;
    int          beat_cnt;
    logic [1:0]  err_phase;

    assign hready = (err_phase == 2'd1) ? 1'b0 : ((dp_v && wait_left != 0) ? 1'b0 : 1'b1);
    assign hresp  = (err_phase != 2'd0);
    assign hrdata = mem[dp_a];

    always @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp_v      <= 1'b0;
            dp_w      <= 1'b0;
            dp_a      <= 3'd0;
            wait_left <= 0;
            beat_cnt  <= 0;
            err_phase <= 2'd0;
        end else begin
            if (start) beat_cnt <= 0;
            if (err_phase == 2'd1) err_phase <= 2'd2;
            else if (err_phase == 2'd2) err_phase <= 2'd0;
            if (dp_v && wait_left != 0) begin
                wait_left <= wait_left - 1;
            end else if (hready) begin
                if (dp_v && dp_w && err_phase == 2'd0)
                    mem[dp_a] <= (flip_en && dp_a == 3'd5) ? (hwdata ^ 32'd1) : hwdata;
                dp_v <= 1'b0;
                if (htrans[1]) begin
                    dp_v      <= 1'b1;
                    dp_w      <= hwrite;
                    dp_a      <= haddr[4:2];
                    beat_cnt  <= beat_cnt + 1;
                    wait_left <= (wait_mode && (beat_cnt % 3 == 2)) ? 2 : 0;
                    if (err_en && hwrite && haddr[4:2] == 3'd3) err_phase <= 2'd1;
                end
            end
        end
    end

    logic [31:0] mem_b [0:3];
    logic        dpb_v;
    logic        dpb_w;
    logic [1:0]  dpb_a;
    logic [1:0]  b_idx;

    assign b_idx    = b_haddr[3:2] - 2'b10;
    assign b_hrdata = mem_b[dpb_a];

    always @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dpb_v <= 1'b0;
            dpb_w <= 1'b0;
            dpb_a <= 2'd0;
        end else begin
            if (dpb_v && dpb_w) mem_b[dpb_a] <= b_hwdata;
            dpb_v <= b_htrans[1];
            dpb_w <= b_hwrite;
            dpb_a <= b_idx;
        end
    end

    int          stab_viol;
    int          wait_cyc;
    logic        last_rdy;
    logic [1:0]  last_trans;
    logic [31:0] last_addr;
    logic        last_write;
    logic [31:0] last_wdata;

    initial begin
        stab_viol = 0;
        wait_cyc  = 0;
        last_rdy  = 1'b1;
        last_trans = 2'b00;
        last_addr  = '0;
        last_write = 1'b0;
        last_wdata = '0;
    end

    always @(negedge HCLK) begin
        if (!last_rdy && last_trans != 2'b00 &&
            (haddr !== last_addr || htrans !== last_trans ||
             hwrite !== last_write || hwdata !== last_wdata))
            stab_viol = stab_viol + 1;
        if (!hready) wait_cyc = wait_cyc + 1;
        last_rdy   = hready;
        last_trans = htrans;
        last_addr  = haddr;
        last_write = hwrite;
        last_wdata = hwdata;
    end

    logic [1:0]  tr_trans [0:39];
    logic [31:0] tr_addr  [0:39];
    logic        tr_write [0:39];
    logic [1:0]  bt_trans [0:7];
    logic [31:0] bt_addr  [0:7];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge HCLK);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    task automatic run_test(output int n);
        pulse_start();
        n = 0;
        while (busy && n < 40) begin
            tr_trans[n] = htrans;
            tr_addr[n]  = haddr;
            tr_write[n] = hwrite;
            n++;
            @(negedge HCLK);
        end
    endtask

    int n;
    int k;
    int w0;
    int s0;

    initial begin
        tests     = 0;
        fails     = 0;
        HRESETN   = 1'b0;
        start     = 1'b0;
        b_start   = 1'b0;
        wait_mode = 1'b0;
        err_en    = 1'b0;
        flip_en   = 1'b0;

        repeat (3) @(negedge HCLK);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_hsel", hsel, 1'b0);
        chk("rst_hwrite", hwrite, 1'b0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_b_haddr", b_haddr, 32'h3F8);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_status", {busy, done, pass, bus_err}, 4'b0000);
        chk("rst_err_cnt", err_cnt, 17'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("hburst", hburst, 3'b001);
        chk("hsize", hsize, 3'b010);
        HRESETN = 1'b1;
        repeat (2) @(negedge HCLK);

        run_test(n);
        chk("t1_busy_cycles", n, 18);
        chk("t1_beat0", {tr_trans[0], tr_write[0], tr_addr[0]}, {2'b10, 1'b1, 32'h0});
        chk("t1_beat1", {tr_trans[1], tr_addr[1]}, {2'b11, 32'h4});
        chk("t1_wr_drain_idle", tr_trans[8], 2'b00);
        chk("t1_rd_beat0", {tr_trans[9], tr_write[9], tr_addr[9]}, {2'b10, 1'b0, 32'h0});
        chk("t1_rd_beat7", {tr_trans[16], tr_addr[16]}, {2'b11, 32'h1C});
        chk("t1_rd_drain_idle", tr_trans[17], 2'b00);
        chk("t1_mem7", mem[7], 32'hA5A5_5A46);
        chk("t1_status", {busy, done, pass, bus_err, hsel}, 5'b01100);
        chk("t1_err_cnt", err_cnt, 17'h0);

        wait_mode = 1'b1;
        w0 = wait_cyc;
        s0 = stab_viol;
        run_test(n);
        chk("t2_busy_cycles", n, 28);
        chk("t2_wait_cycles", wait_cyc - w0, 10);
        chk("t2_stable_in_wait", stab_viol - s0, 0);
        chk("t2_pass", {done, pass}, 2'b11);
        wait_mode = 1'b0;

        flip_en = 1'b1;
        run_test(n);
        chk("t3_mem5", mem[5], 32'hA5A5_5A4F);
        chk("t3_err_cnt", err_cnt, 17'd1);
        chk("t3_err_addr", err_addr, 32'h14);
        chk("t3_status", {done, pass, bus_err}, 3'b100);
        flip_en = 1'b0;

        @(negedge HCLK);
        b_start = 1'b1;
        @(negedge HCLK);
        b_start = 1'b0;
        k = 0;
        n = 0;
        while (b_busy && n < 40) begin
            if (b_htrans != 2'b00 && k < 8) begin
                bt_trans[k] = b_htrans;
                bt_addr[k]  = b_haddr;
                k++;
            end
            n++;
            @(negedge HCLK);
        end
        chk("t4_beats", k, 8);
        chk("t4_wr_trans", {bt_trans[0], bt_trans[1], bt_trans[2], bt_trans[3]}, 8'b10_11_10_11);
        chk("t4_rd_trans", {bt_trans[4], bt_trans[5], bt_trans[6], bt_trans[7]}, 8'b10_11_10_11);
        chk("t4_addr2", bt_addr[2], 32'h400);
        chk("t4_addr3", bt_addr[3], 32'h404);
        chk("t4_addr5", bt_addr[5], 32'h3FC);
        chk("t4_status", {b_done, b_pass, b_bus_err, b_hsel}, 4'b1100);
        chk("t4_err", {b_err_cnt, b_err_addr}, 49'h0);
        chk("t4_ctrl", {b_hburst, b_hsize}, 6'b001_010);

        err_en = 1'b1;
        pulse_start();
        n = 0;
        while (!hresp && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        chk("t5_err_seen", hresp, 1'b1);
        chk("t5_first_cycle", {htrans, hready}, {2'b11, 1'b0});
        @(negedge HCLK);
        chk("t5_idle_after_err", {htrans, hsel}, {2'b00, 1'b0});
        n = 0;
        while (!done && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        chk("t5_status", {done, pass, bus_err, busy}, 4'b1010);
        chk("t5_err_addr", err_addr, 32'hC);
        chk("t5_err_cnt", err_cnt, 17'h0);
        err_en = 1'b0;

        flip_en = 1'b1;
        pulse_start();
        n = 0;
        while (err_cnt == 17'd0 && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        chk("t6_pre_err", {err_cnt, busy, hwrite}, {17'd1, 1'b1, 1'b0});
        HRESETN = 1'b0;
        #1;
        chk("t6_rst_bus", {htrans, hsel, busy, done}, {2'b00, 1'b0, 1'b0, 1'b0});
        chk("t6_rst_err", {err_cnt, err_addr}, 49'h0);
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;
        flip_en = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("t6_no_autostart", {htrans, busy, done}, {2'b00, 1'b0, 1'b0});
        run_test(n);
        chk("t6_busy_cycles", n, 18);
        chk("t6_status", {done, pass, bus_err}, 3'b110);
        chk("t6_err", {err_cnt, err_addr}, 49'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
